// File: rtl/ring_nic.sv
// ring_nic: network interface between one processing element and the PE port
// of its ring router. It has a one-entry input (ejection) buffer that the
// processor reads and a one-entry output (injection) buffer that the processor
// writes. Injection is gated by the packet's VC bit so that even packets leave
// only on even cycles and odd packets leave only on odd cycles.
module ring_nic #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] d_out,
    input  logic          nicEn,
    input  logic          nicWrEn,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [DW-1:0] net_di,
    output logic          net_so,
    input  logic          net_ro,
    output logic [DW-1:0] net_do,
    input  logic          net_polarity
);

    localparam logic [1:0] AddrInBuf     = 2'b00;
    localparam logic [1:0] AddrInStatus  = 2'b01;
    localparam logic [1:0] AddrOutBuf    = 2'b10;
    localparam logic [1:0] AddrOutStatus = 2'b11;

    logic [DW-1:0] inBuf_q,   inBuf_d;
    logic          inFull_q,  inFull_d;
    logic [DW-1:0] outBuf_q,  outBuf_d;
    logic          outFull_q, outFull_d;
    logic [DW-1:0] dOut_q,    dOut_d;

    logic readEn;
    logic writeEn;
    logic capture;
    logic inject;

    // Decode processor access, ejection capture and injection for this cycle.
    always_comb begin
        readEn  = nicEn & ~nicWrEn;
        writeEn = nicEn &  nicWrEn;
        capture = net_si & ~inFull_q;
        inject  = outFull_q & net_ro & (net_polarity == outBuf_q[DW-1]);
    end

    // Input buffer: capture an ejected packet when empty; a read of the buffer
    // register frees it. The two never collide because capture needs empty.
    always_comb begin
        inBuf_d  = inBuf_q;
        inFull_d = inFull_q;
        if (readEn && (addr == AddrInBuf)) begin
            inFull_d = 1'b0;
        end
        if (capture) begin
            inBuf_d  = net_di;
            inFull_d = 1'b1;
        end
    end

    // Output buffer: a processor write fills it only when empty, otherwise the
    // write is dropped; a completed injection frees it.
    always_comb begin
        outBuf_d  = outBuf_q;
        outFull_d = outFull_q;
        if (inject) begin
            outFull_d = 1'b0;
        end
        if (writeEn && (addr == AddrOutBuf) && !outFull_q) begin
            outBuf_d  = d_in;
            outFull_d = 1'b1;
        end
    end

    // Registered read data; holds its value when no read is issued.
    always_comb begin
        dOut_d = dOut_q;
        if (readEn) begin
            case (addr)
                AddrInBuf:     dOut_d = inBuf_q;
                AddrInStatus:  dOut_d = {{(DW-1){1'b0}}, inFull_q};
                AddrOutBuf:    dOut_d = '0;
                AddrOutStatus: dOut_d = {{(DW-1){1'b0}}, outFull_q};
                default:       dOut_d = dOut_q;
            endcase
        end
    end

    // State registers with synchronous reset that discards any buffered packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            inBuf_q   <= '0;
            inFull_q  <= 1'b0;
            outBuf_q  <= '0;
            outFull_q <= 1'b0;
            dOut_q    <= '0;
        end else begin
            inBuf_q   <= inBuf_d;
            inFull_q  <= inFull_d;
            outBuf_q  <= outBuf_d;
            outFull_q <= outFull_d;
            dOut_q    <= dOut_d;
        end
    end

    assign d_out  = dOut_q;
    assign net_ri = ~inFull_q;
    assign net_so = inject;
    assign net_do = outBuf_q;

endmodule

// File: doc/ring_nic.md
# ring_nic

Network interface controller joining one processing element to its ring router's PE port. It holds a one-entry output channel buffer, which the processor writes and which injects toward the router's PE input port (pedi / grant path). It also holds a one-entry input channel buffer, which captures packets ejected by the router and which the processor reads. The processor side is a small memory-mapped register port. The network side uses the same send/ready handshake and even/odd polarity scheme as the ring buffers.

## Interface
Parameters:
- DW, 64, packet width. Bit [63] is the VC (0 = even, 1 = odd); the remaining bits pass through untouched.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  in  DW  processor write data.
- d_out  out  DW  processor read data (registered).
- nicEn  in  1  register access enable.
- nicWrEn  in  1  1 = write, 0 = read; only meaningful when nicEn=1.
- net_si  in  1  router presents an ejected packet.
- net_ri  out  1  NIC can accept an ejected packet.
- net_di  in  DW  ejected packet.
- net_so  out  1  NIC injects the packet on net_do this cycle.
- net_ro  in  1  router PE input port can accept a packet.
- net_do  out  DW  injected packet (the output buffer contents).
- net_polarity  in  1  ring polarity; 0 = even cycle, 1 = odd cycle.

## Operation
- State: in_buf[DW-1:0], in_full, out_buf[DW-1:0], out_full, d_out.
- Reset: all five state items clear to 0, so d_out=0, net_ri=1, net_so=0 and net_do=0.
- **Ejection:** net_ri = ~in_full (combinational).
  - When net_si && !in_full, the edge loads in_buf <= net_di and sets in_full <= 1.
  - When net_si && in_full, nothing is captured; the router must hold the packet.
- **Processor read** (nicEn=1, nicWrEn=0): d_out is loaded at the edge.
  - 00: d_out <= in_buf, and in_full clears if it was set. Reading while empty returns stale in_buf and has no side effect.
  - 01: d_out <= {63'b0, in_full}.
  - 10: d_out <= 0.
  - 11: d_out <= {63'b0, out_full}.
  - When there is no read, d_out holds.
- **Processor write** (nicEn=1, nicWrEn=1):
  - Addr 10 with !out_full loads out_buf <= d_in and sets out_full <= 1.
  - Addr 10 while out_full is dropped silently, and the buffer is unchanged.
  - Writes to 00, 01 and 11 are ignored.
- **Injection:** net_so = out_full & net_ro & (net_polarity == out_buf[63]) (combinational). net_do = out_buf at all times.
  - A packet tagged even injects only on even cycles; a packet tagged odd injects only on odd cycles.
  - When net_so=1 at an edge, out_full clears.
- **Simultaneous events:**
  - Read of 00 and net_si in the same cycle: net_ri was 0, so no capture happens; in_full clears, and a new capture is possible from the next cycle.
  - Write to 10 and injection in the same cycle: out_full was 1, so the write is dropped and the injection completes. The processor must poll 11 before writing.
  - Reset asserted mid-transfer overrides everything; any buffered packets are lost.

## Timing
- Ejection to visibility: a capture at edge N gives status 01 = 1 if read at edge N+1 or later.
- Register read latency is 1 cycle: address presented in cycle N, d_out valid after edge N.
- Write to 10 at edge N sets out_full; net_so can first assert in cycle N+1, subject to net_ro and polarity.
- Worst-case injection wait after net_ro is high is 1 extra cycle for polarity alignment.
- Sustained throughput is 1 packet per 2 cycles per direction (fill, then drain, of a 1-entry buffer).

## Test plan
- **Reset:** reset=1 for 2 cycles -> d_out=0, net_ri=1, net_so=0, net_do=0; read 01 and 11 both return 0.
- **Ejection:**
  - net_si=1 with net_di=64'hA5A5_0000_0000_0001 -> net_ri=0 next cycle.
  - Read 01 returns 1.
  - Read 00 returns A5A5_0000_0000_0001, then net_ri=1.
  - A second net_si while full is not captured; in_buf is unchanged.
- **Polarity-gated injection:**
  - Write 10 with d_in=64'h8000_0000_0000_0042 (odd VC), net_ro=1, polarity toggling from 0 -> net_so stays 0 on even cycles and pulses exactly one odd cycle with net_do=8000_0000_0000_0042.
  - Read 11 afterward returns 0.
- **Backpressure:** out_full=1, net_ro=0 for 10 cycles -> net_so=0 throughout and out_buf is held; raising net_ro gives injection within 2 cycles.
- **Write while full:**
  - Write 10 with value 1, then immediately write 10 with value 2 while net_ro=0 -> net_do remains 1.
  - After drain, write 2 succeeds.
- **Reset mid-operation:** both buffers full, assert reset for 1 cycle -> in_full=0, out_full=0, net_so=0, net_ri=1, d_out=0 on the following cycle.
